// File: rtl/xbuf_pkg.sv
// Shared types and default sizing for the transfer-buffer host-side scheduler.
package xbuf_pkg;

  localparam int unsigned WORDS_PER_BURST_DEF = 1024;
  localparam int unsigned GS_WIDTH_DEF        = 8;
  localparam int unsigned MAX_BUFQ_DEPTH      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STATUS = 3'd1,
    ST_CHECK  = 3'd2,
    ST_BURST  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; the pointer moves away from the last served requester.
module rr_arbiter2 (
  input  logic       clock_host,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       winner,
  output logic       grant_idx_c
);

  logic rr;

  always_ff @(posedge clock_host) begin
    if (reset) begin
      rr <= 1'b0;
    end else if (update) begin
      rr <= ~winner;
    end
  end

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_idx_c = 1'b0;
    unique case (req)
      2'b01:   grant_idx_c = 1'b0;
      2'b10:   grant_idx_c = 1'b1;
      2'b11:   grant_idx_c = rr;
      default: grant_idx_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/xbuf_host_scheduler.sv
// Host-side scheduler: arbitrates two requesters, checks buffer status, then runs one
// fixed-length burst on the buffer host port and signals completion.
module xbuf_host_scheduler
  import xbuf_pkg::*;
#(
  parameter int unsigned WORDS_PER_BURST = WORDS_PER_BURST_DEF,
  parameter int unsigned GS_WIDTH        = GS_WIDTH_DEF
) (
  input  logic                clock_host,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          req_write,
  input  logic [GS_WIDTH-1:0] gs_out,
  input  logic                gs_out_enable,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                word_strobe,
  output logic                host_select,
  output logic                hwrite_enable,
  output logic                gs_select,
  output logic                gs_write_enable,
  output logic                busy
);

  localparam int unsigned       BEAT_W    = $clog2(WORDS_PER_BURST) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BURST - 1);

  state_t            state, state_nxt;
  logic              win_idx, win_idx_nxt;
  logic              win_dir, win_dir_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic              arb_idx;
  logic              gs_ok;
  logic              rr_update;

  logic [1:0] gnt_d, done_d;
  logic       word_strobe_d, host_select_d, hwrite_enable_d;
  logic       gs_select_d, gs_write_enable_d, busy_d;

  assign gs_ok     = gs_out_enable && (gs_out != '0);
  assign rr_update = ((state == ST_CHECK) && !gs_ok) || (state == ST_DONE);

  rr_arbiter2 u_arb (
    .clock_host  (clock_host),
    .reset       (reset),
    .req         (req),
    .update      (rr_update),
    .winner      (win_idx),
    .grant_idx_c (arb_idx)
  );

  // State, latched winner and beat counter
  always_ff @(posedge clock_host) begin
    if (reset) begin
      state   <= ST_IDLE;
      win_idx <= 1'b0;
      win_dir <= 1'b0;
      beat    <= '0;
    end else begin
      state   <= state_nxt;
      win_idx <= win_idx_nxt;
      win_dir <= win_dir_nxt;
      beat    <= beat_nxt;
    end
  end

  // Next state; requester inputs are only looked at while idle
  always_comb begin
    state_nxt   = state;
    win_idx_nxt = win_idx;
    win_dir_nxt = win_dir;
    beat_nxt    = beat;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt   = ST_STATUS;
          win_idx_nxt = arb_idx;
          win_dir_nxt = req_write[arb_idx];
        end
      end
      ST_STATUS: state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (gs_ok) begin
          state_nxt = ST_BURST;
          beat_nxt  = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        beat_nxt = beat + BEAT_W'(1);
        if (beat == LAST_BEAT) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so the registered ports line up with it
  always_comb begin
    gnt_d             = '0;
    done_d            = '0;
    word_strobe_d     = 1'b0;
    host_select_d     = 1'b0;
    hwrite_enable_d   = 1'b0;
    gs_select_d       = 1'b0;
    gs_write_enable_d = 1'b0;
    busy_d            = (state_nxt != ST_IDLE);
    unique case (state_nxt)
      ST_STATUS: begin
        gs_select_d       = 1'b1;
        gs_write_enable_d = win_dir_nxt;
      end
      ST_CHECK: gs_select_d = 1'b1;
      ST_BURST: begin
        gnt_d[win_idx_nxt] = 1'b1;
        host_select_d      = 1'b1;
        hwrite_enable_d    = win_dir_nxt;
        word_strobe_d      = 1'b1;
      end
      ST_DONE: done_d[win_idx_nxt] = 1'b1;
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock_host) begin
    if (reset) begin
      gnt             <= '0;
      done            <= '0;
      word_strobe     <= 1'b0;
      host_select     <= 1'b0;
      hwrite_enable   <= 1'b0;
      gs_select       <= 1'b0;
      gs_write_enable <= 1'b0;
      busy            <= 1'b0;
    end else begin
      gnt             <= gnt_d;
      done            <= done_d;
      word_strobe     <= word_strobe_d;
      host_select     <= host_select_d;
      hwrite_enable   <= hwrite_enable_d;
      gs_select       <= gs_select_d;
      gs_write_enable <= gs_write_enable_d;
      busy            <= busy_d;
    end
  end

endmodule
